// File: rtl/addr_reg_pkg.sv
// addr_reg_pkg: shared types, index-width helper and limit reset value for addr_reg_bank.
package addr_reg_pkg;
  localparam logic [63:0] LIM_RST = '1;
  typedef struct packed {
    logic clr;
    logic wr;
    logic inc;
    logic dec;
  } req_t;
  function automatic int selw(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/addr_reg_cell.sv
// addr_reg_cell: one register with clr/wr/inc/dec priority, step arithmetic and wrap flag.
// Optional per-register limit register under ADDR_REG_LIMIT_EN.
module addr_reg_cell import addr_reg_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  req_t             req,
  input  logic [WIDTH-1:0] din,
`ifdef ADDR_REG_LIMIT_EN
  input  logic             lim_wr,
  input  logic [WIDTH-1:0] lim_din,
`endif
  output logic [WIDTH-1:0] q,
  output logic             wrap
);
  localparam logic [WIDTH:0] ST  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  logic [WIDTH-1:0] lim, nxt;
  logic [WIDTH:0] up, dn, lim1;
  logic up_w, nw, step;
`ifdef ADDR_REG_LIMIT_EN
  always_ff @(posedge clk)
    if (RST) lim <= LIM_RST[WIDTH-1:0];
    else if (lim_wr) lim <= lim_din;
`else
  assign lim = LIM_RST[WIDTH-1:0];
`endif
  // the unlimited build is the limit case with L = 2^WIDTH-1
  always_comb begin
    lim1 = {1'b0, lim} + ONE;
    up   = {1'b0, q} + ST;
    dn   = {1'b0, q} - ST;
    up_w = up > {1'b0, lim};
    nxt  = req.inc ? WIDTH'(up_w ? up - lim1 : up) : WIDTH'(dn[WIDTH] ? dn + lim1 : dn);
    nw   = req.inc ? up_w : dn[WIDTH];
    step = !req.clr && !req.wr && (req.inc ^ req.dec);
  end
  always_ff @(posedge clk)
    if (RST) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= step && nw;
      if (req.clr) q <= '0;
      else if (req.wr) q <= din;
      else if (step) q <= nxt;
    end
endmodule

// File: rtl/addr_reg_bank.sv
// addr_reg_bank: NREG-register bank with index decode and registered read mux.
// Define ADDR_REG_LIMIT_EN for per-register wrap limits and the lim_* port.
module addr_reg_bank import addr_reg_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int STEP  = 1,
  localparam int SELW = selw(NREG)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clr,
  input  logic [SELW-1:0]  clr_sel,
  input  logic             wr,
  input  logic [SELW-1:0]  wr_sel,
  input  logic [WIDTH-1:0] din,
  input  logic [NREG-1:0]  inc,
  input  logic [NREG-1:0]  dec,
  input  logic             rd,
  input  logic [SELW-1:0]  rd_sel,
`ifdef ADDR_REG_LIMIT_EN
  input  logic             lim_wr,
  input  logic [SELW-1:0]  lim_sel,
  input  logic [WIDTH-1:0] lim_din,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [NREG-1:0]  wrap
);
  // padded to the full index space so out-of-range reads return 0
  logic [WIDTH-1:0] qa [2**SELW];
  for (genvar i = 0; i < 2**SELW; i++) begin : g
    if (i < NREG) begin : c
      req_t req;
      assign req = '{clr: clr && clr_sel == SELW'(i), wr: wr && wr_sel == SELW'(i),
                     inc: inc[i], dec: dec[i]};
      addr_reg_cell #(.WIDTH(WIDTH), .STEP(STEP)) u_cell (
        .clk     (clk),
        .RST     (RST),
        .req     (req),
        .din     (din),
`ifdef ADDR_REG_LIMIT_EN
        .lim_wr  (lim_wr && lim_sel == SELW'(i)),
        .lim_din (lim_din),
`endif
        .q       (qa[i]),
        .wrap    (wrap[i])
      );
    end else begin : z
      assign qa[i] = '0;
    end
  end
  always_ff @(posedge clk)
    if (RST) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd;
      dout     <= rd ? qa[rd_sel] : '0;
    end
endmodule

// File: tb/tb_addr_reg_bank.sv
// tb_addr_reg_bank: table-driven check of a 4x16 STEP=1 bank plus a 3x16 STEP=4 bank.
module tb_addr_reg_bank;
  logic clk = 0, RST = 1;
  always #5 clk = ~clk;

  logic a_clr, a_wr, a_rd, a_vld;
  logic [1:0] a_cs, a_ws, a_rs;
  logic [15:0] a_din, a_dout;
  logic [3:0] a_inc, a_dec, a_wrap;
  logic b_clr, b_wr, b_rd, b_vld;
  logic [1:0] b_cs, b_ws, b_rs;
  logic [15:0] b_din, b_dout;
  logic [2:0] b_inc, b_dec, b_wrap;
`ifdef ADDR_REG_LIMIT_EN
  logic a_lw = 0, b_lw = 0;
  logic [1:0] a_ls = 0, b_ls = 0;
  logic [15:0] a_ld = 0, b_ld = 0;
`endif

  addr_reg_bank #(.WIDTH(16), .NREG(4), .STEP(1)) dut_a (
    .clk(clk), .RST(RST), .clr(a_clr), .clr_sel(a_cs), .wr(a_wr), .wr_sel(a_ws),
    .din(a_din), .inc(a_inc), .dec(a_dec), .rd(a_rd), .rd_sel(a_rs),
`ifdef ADDR_REG_LIMIT_EN
    .lim_wr(a_lw), .lim_sel(a_ls), .lim_din(a_ld),
`endif
    .dout(a_dout), .dout_vld(a_vld), .wrap(a_wrap));

  addr_reg_bank #(.WIDTH(16), .NREG(3), .STEP(4)) dut_b (
    .clk(clk), .RST(RST), .clr(b_clr), .clr_sel(b_cs), .wr(b_wr), .wr_sel(b_ws),
    .din(b_din), .inc(b_inc), .dec(b_dec), .rd(b_rd), .rd_sel(b_rs),
`ifdef ADDR_REG_LIMIT_EN
    .lim_wr(b_lw), .lim_sel(b_ls), .lim_din(b_ld),
`endif
    .dout(b_dout), .dout_vld(b_vld), .wrap(b_wrap));

  typedef struct {
    logic clr; logic [1:0] cs; logic wr; logic [1:0] ws; logic [15:0] din;
    logic [3:0] inc, dec; logic rd; logic [1:0] rs;
    logic [15:0] dout; logic vld; logic [3:0] wrap;
  } vec_t;

  int total = 0, bad = 0;
  vec_t v [24];

  function automatic vec_t mk(input logic clr, input logic [1:0] cs, input logic wr,
      input logic [1:0] ws, input logic [15:0] din, input logic [3:0] inc, input logic [3:0] dec,
      input logic rd, input logic [1:0] rs, input logic [15:0] dout, input logic vld,
      input logic [3:0] wrap);
    vec_t r;
    r = '{clr, cs, wr, ws, din, inc, dec, rd, rs, dout, vld, wrap};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = mk(0,0, 1,2,16'hFFFE, 4'b0000,4'b0000, 1,3, 16'h0000,1,4'b0000);
    v[1]  = mk(0,0, 0,0,16'h0000, 4'b0100,4'b0000, 0,0, 16'h0000,0,4'b0000);
    v[2]  = mk(0,0, 0,0,16'h0000, 4'b0100,4'b0000, 0,0, 16'h0000,0,4'b0100);
    v[3]  = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0000, 1,2, 16'h0000,1,4'b0000);
    v[4]  = mk(0,0, 1,1,16'h0005, 4'b0000,4'b0000, 0,0, 16'h0000,0,4'b0000);
    v[5]  = mk(0,0, 1,1,16'h1234, 4'b0000,4'b0000, 1,1, 16'h0005,1,4'b0000);
    v[6]  = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0000, 1,1, 16'h1234,1,4'b0000);
    v[7]  = mk(0,0, 1,0,16'h00AA, 4'b0000,4'b0000, 0,0, 16'h0000,0,4'b0000);
    v[8]  = mk(1,0, 1,0,16'h5555, 4'b0001,4'b0000, 1,0, 16'h00AA,1,4'b0000);
    v[9]  = mk(0,0, 1,3,16'h0010, 4'b0000,4'b0000, 1,0, 16'h0000,1,4'b0000);
    v[10] = mk(0,0, 0,0,16'h0000, 4'b1000,4'b1000, 1,3, 16'h0010,1,4'b0000);
    v[11] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0000, 1,3, 16'h0010,1,4'b0000);
    v[12] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0001, 1,2, 16'h0000,1,4'b0001);
    v[13] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0001, 1,0, 16'hFFFF,1,4'b0000);
    v[14] = mk(0,0, 0,0,16'h0000, 4'b0110,4'b0000, 1,0, 16'hFFFE,1,4'b0000);
    v[15] = mk(0,0, 0,0,16'h0000, 4'b0100,4'b0000, 1,1, 16'h1235,1,4'b0000);
    v[16] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0000, 1,2, 16'h0002,1,4'b0000);
    v[17] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0000, 0,0, 16'h0000,0,4'b0000);
    v[18] = mk(0,0, 1,3,16'hFFFF, 4'b0000,4'b0000, 0,0, 16'h0000,0,4'b0000);
    v[19] = mk(0,0, 0,0,16'h0000, 4'b1000,4'b0000, 0,0, 16'h0000,0,4'b1000);
    v[20] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b1000, 0,0, 16'h0000,0,4'b1000);
    v[21] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0000, 1,3, 16'hFFFF,1,4'b0000);
    v[22] = mk(0,0, 1,3,16'h0007, 4'b1000,4'b0000, 0,0, 16'h0000,0,4'b0000);
    v[23] = mk(0,0, 0,0,16'h0000, 4'b0000,4'b0000, 1,3, 16'h0007,1,4'b0000);

    // reset with every request active
    a_clr = 1; a_cs = 0; a_wr = 1; a_ws = 1; a_din = 16'hFFFF; a_inc = '1; a_dec = 0;
    a_rd = 1; a_rs = 3;
    b_clr = 0; b_cs = 0; b_wr = 1; b_ws = 2; b_din = 16'h00FF; b_inc = '1; b_dec = 0;
    b_rd = 1; b_rs = 2;
    RST = 1;
    tick; tick;
    chk("rst_dout", a_dout, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_wrap", a_wrap, 0);
    chk("rst_b_vld", b_vld, 0);
    RST = 0;
    b_wr = 0; b_inc = 0; b_rd = 0;

    for (int k = 0; k < 24; k++) begin
      a_clr = v[k].clr; a_cs = v[k].cs; a_wr = v[k].wr; a_ws = v[k].ws; a_din = v[k].din;
      a_inc = v[k].inc; a_dec = v[k].dec; a_rd = v[k].rd; a_rs = v[k].rs;
      tick;
      chk($sformatf("v%0d_dout", k), a_dout, v[k].dout);
      chk($sformatf("v%0d_vld", k), a_vld, v[k].vld);
      chk($sformatf("v%0d_wrap", k), a_wrap, v[k].wrap);
    end

    // reset mid-operation, then confirm reg3 (was 7) is cleared and not incremented
    a_clr = 0; a_wr = 0; a_dec = 0; a_inc = 4'b1000; a_rd = 1; a_rs = 3; RST = 1;
    tick;
    chk("mid_rst_vld", a_vld, 0);
    chk("mid_rst_dout", a_dout, 0);
    RST = 0; a_inc = 0;
    tick;
    chk("post_rst_rd3", a_dout, 0);
    chk("post_rst_vld", a_vld, 1);
    a_rd = 0;

    // STEP=4 underflow and out-of-range index on the 3-register bank
    b_wr = 1; b_ws = 1; b_din = 16'h0002;
    tick;
    b_wr = 0; b_dec = 3'b010;
    tick;
    chk("b_dec_wrap", b_wrap, 3'b010);
    b_dec = 0; b_rd = 1; b_rs = 1;
    tick;
    chk("b_dec_val", b_dout, 16'hFFFE);
    chk("b_wrap_end", b_wrap, 0);
    b_wr = 1; b_ws = 3; b_din = 16'h1111; b_rs = 3;
    tick;
    chk("b_oob_dout", b_dout, 0);
    chk("b_oob_vld", b_vld, 1);
    b_wr = 0; b_clr = 1; b_cs = 3; b_rs = 0;
    tick;
    chk("b_rd0", b_dout, 0);
    b_clr = 0; b_rs = 1;
    tick;
    chk("b_rd1_kept", b_dout, 16'hFFFE);
    b_rs = 2;
    tick;
    chk("b_rd2", b_dout, 0);
    b_rd = 0;
    tick;
    chk("b_idle_vld", b_vld, 0);
    chk("b_idle_dout", b_dout, 0);
`ifdef ADDR_REG_LIMIT_EN
    b_lw = 1; b_ls = 1; b_ld = 16'd9; b_wr = 1; b_ws = 1; b_din = 16'd8;
    tick;
    b_lw = 0; b_wr = 0; b_inc = 3'b010;
    tick;
    chk("b_lim_wrap", b_wrap, 3'b010);
    b_inc = 0; b_rd = 1; b_rs = 1;
    tick;
    chk("b_lim_val", b_dout, 16'd2);
    b_rd = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
